uart_port_ctrl: RTL and testbench
=================================

UART_PORT_CTRL -- requirements
Module: uart_port_ctrl

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- DATA_W, 8, UART character width (5..8).
- DEPTH, 16, depth of each FIFO (power of 2, 2..256).
- BASE_ADDR, 16'h0000, port_id of register 0.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, 100MHz clock.
- reset, in, 1, synchronous active-high reset.
- port_id, in, 16, processor port address.
- out_port, in, 16, processor write data.
- write_strobe, in, 1, one-cycle write qualifier.
- read_strobe, in, 1, one-cycle read qualifier.
- in_port, out, 16, processor read data.
- interrupt, out, 1, level interrupt to processor.
- interrupt_ack, in, 1, interrupt acknowledge.
- tx_data, out, DATA_W, character to the TX engine.
- tx_load, out, 1, one-cycle load pulse to the TX engine.
- tx_rdy, in, 1, TX engine idle.
- rx_data, in, DATA_W, character from the RX engine.
- rx_valid, in, 1, one-cycle pulse when a character is received.
- rx_ferr, in, 1, framing error, qualified by rx_valid.
- rx_perr, in, 1, parity error, qualified by rx_valid.
REQ-003 The block SHALL use one clock (clk); reset SHALL be synchronous and active-high.

Function
REQ-004 Register map (BASE_ADDR offset): +0 DATA, +1 STATUS, +2 CTRL, +3 COUNT; all other addresses ignored, in_port reads 0.
REQ-005 DATA write with write_strobe SHALL push out_port[DATA_W-1:0] into TX FIFO; if TX FIFO full, data dropped, TX_OVF set.
REQ-006 DATA read with read_strobe SHALL pop RX FIFO; in_port = zero-extended head, combinational from port_id; pop on empty is a no-op returning 0.
REQ-007 STATUS = {9'b0, TX_IDLE, TX_OVF, RX_OVF, PERR, FERR, TX_NFULL, RX_NEMPTY}; read_strobe on STATUS SHALL clear bits [5:2] next cycle, unless set the same cycle (set wins).
REQ-008 CTRL[3:0] = interrupt enables {TX_EMPTY, ERR, TX_NFULL, RX_NEMPTY}; read/write; CTRL[4] loopback (REQ-018).
REQ-009 COUNT = {rx_count[7:0], tx_count[7:0]}, occupancy 0..DEPTH (DEPTH=256 saturates to 255 in readback).
REQ-010 rx_valid SHALL push rx_data into RX FIFO; FERR/PERR set from rx_ferr/rx_perr; if full (evaluated before a same-cycle pop), character dropped, RX_OVF set.
REQ-011 TX launcher FSM states IDLE, LOAD, BUSY: IDLE->LOAD when TX FIFO non-empty and tx_rdy; LOAD asserts tx_load one cycle with tx_data=head, pops, ->BUSY; BUSY->IDLE when tx_rdy observed low or after 2 cycles in BUSY, whichever first.
REQ-012 tx_data SHALL hold the last loaded character outside LOAD.
REQ-013 TX_IDLE = TX FIFO empty & FSM IDLE & tx_rdy.
REQ-014 interrupt SHALL be set on the rising edge of (enabled RX_NEMPTY | TX_NFULL | FERR|PERR|RX_OVF|TX_OVF | TX_IDLE), cleared by interrupt_ack; simultaneous set and ack: set wins.
REQ-015 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep count unchanged; pointers SHALL wrap modulo DEPTH.

Reset
REQ-016 reset SHALL clear FIFO pointers/counts, all sticky flags, CTRL, interrupt, tx_load, tx_data, and FSM->IDLE; in_port follows combinationally.
REQ-017 reset mid-transfer SHALL discard FIFO contents; no tx_load is issued in the cycle after reset.

Configuration
REQ-018 Macro UART_LOOPBACK_EN: when defined, CTRL[4]=1 routes each LOAD character into RX FIFO (with RX_OVF rules) and suppresses tx_load; when undefined, CTRL[4] reads 0, writes ignored, no loopback logic.

Structure
REQ-019 Shared package uart_pkg SHALL hold register offsets, STATUS/CTRL bit indices and the FSM state enum.
REQ-020 One sub-module, uart_sync_fifo (DATA_W, DEPTH), instantiated twice for RX and TX.

Verification
REQ-021 Write 8'h41,8'h42 to DATA with tx_rdy=1 -> two tx_load pulses, tx_data 41 then 42, COUNT[7:0] returns 0.
REQ-022 DEPTH=16, tx_rdy=0, 17 DATA writes -> COUNT[7:0]=16, STATUS[5]=1; STATUS read clears it.
REQ-023 17 rx_valid pulses, no reads -> 16 stored, RX_OVF=1; reads return characters in order, 17th lost.
REQ-024 CTRL=4'b0001, rx_valid with 8'h55 -> interrupt=1 next cycle; interrupt_ack -> 0; DATA read returns 16'h0055.
REQ-025 rx_valid with rx_ferr=1 during STATUS read -> FERR remains 1.
REQ-026 UART_LOOPBACK_EN defined, CTRL=5'h10, write 8'hA5 -> no tx_load, RX read returns 16'h00A5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART port controller: register offsets, STATUS/CTRL
// bit positions and the TX launcher state encoding.
package uart_pkg;

  localparam logic [15:0] OFF_DATA   = 16'd0;
  localparam logic [15:0] OFF_STATUS = 16'd1;
  localparam logic [15:0] OFF_CTRL   = 16'd2;
  localparam logic [15:0] OFF_COUNT  = 16'd3;

  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_TX_NFULL  = 1;
  localparam int ST_FERR      = 2;
  localparam int ST_PERR      = 3;
  localparam int ST_RX_OVF    = 4;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_TX_IDLE   = 6;

  localparam int CT_IE_RX_NEMPTY = 0;
  localparam int CT_IE_TX_NFULL  = 1;
  localparam int CT_IE_ERR       = 2;
  localparam int CT_IE_TX_EMPTY  = 3;
  localparam int CT_LOOPBACK     = 4;

  typedef enum logic [1:0] {
    TX_IDLE_S = 2'd0,
    TX_LOAD_S = 2'd1,
    TX_BUSY_S = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with head-of-queue read data. A push while full is ignored
// (fullness is judged before any same-cycle pop); a pop while empty is ignored.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_count == CNT_MAX);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_port_ctrl.sv
// Processor-port UART controller: RX/TX FIFOs, sticky status, interrupt and TX
// launcher. Optional loopback (CTRL[4]) is built only with UART_LOOPBACK_EN.
module uart_port_ctrl
  import uart_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       port_id,
  input  logic [15:0]       out_port,
  input  logic              write_strobe,
  input  logic              read_strobe,
  output logic [15:0]       in_port,
  output logic              interrupt,
  input  logic              interrupt_ack,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  input  logic              tx_rdy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  input  logic              rx_perr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              w_sel_data, w_sel_status, w_sel_ctrl, w_sel_count;
  logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [DATA_W-1:0] w_rx_wdata, w_rx_head, w_tx_head;
  logic [CW-1:0]     w_rx_count, w_tx_count;
  logic [15:0]       w_rx_cnt16, w_tx_cnt16;
  logic [7:0]        w_rx_cnt8, w_tx_cnt8;
  logic              w_lpbk, w_lb_drop, w_tx_idle, w_st_clr, w_err, w_irq_src;
  logic [15:0]       w_status, w_ctrl_rb;
  logic              w_unused_ok;

  tx_state_t         r_state, w_state_nxt;
  logic              r_busy_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic [3:0]        r_ien;
  logic              r_ferr, r_perr, r_rx_ovf, r_tx_ovf;
  logic              r_irq, r_irq_src_d;

  assign w_sel_data   = (port_id == BASE_ADDR + OFF_DATA);
  assign w_sel_status = (port_id == BASE_ADDR + OFF_STATUS);
  assign w_sel_ctrl   = (port_id == BASE_ADDR + OFF_CTRL);
  assign w_sel_count  = (port_id == BASE_ADDR + OFF_COUNT);
  assign w_unused_ok  = &{1'b0, out_port[15:4]};

  assign w_tx_push = write_strobe & w_sel_data;
  assign w_rx_pop  = read_strobe & w_sel_data;
  assign w_st_clr  = read_strobe & w_sel_status;

`ifdef UART_LOOPBACK_EN
  logic r_lpbk;
  logic w_lb_push;
  // A looped-back character colliding with a real rx_valid is lost and flagged as RX overflow.
  assign w_lb_push  = (r_state == TX_LOAD_S) & r_lpbk;
  assign w_rx_push  = rx_valid | w_lb_push;
  assign w_rx_wdata = rx_valid ? rx_data : w_tx_head;
  assign w_lb_drop  = rx_valid & w_lb_push;
  assign w_lpbk     = r_lpbk;
  always_ff @(posedge clk) begin
    if (reset)                          r_lpbk <= 1'b0;
    else if (write_strobe & w_sel_ctrl) r_lpbk <= out_port[CT_LOOPBACK];
  end
`else
  assign w_rx_push  = rx_valid;
  assign w_rx_wdata = rx_data;
  assign w_lb_drop  = 1'b0;
  assign w_lpbk     = 1'b0;
`endif

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(w_rx_push), .pop(w_rx_pop), .wdata(w_rx_wdata),
    .rdata(w_rx_head), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
  );

  uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(w_tx_push), .pop(w_tx_pop), .wdata(out_port[DATA_W-1:0]),
    .rdata(w_tx_head), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_pop    = 1'b0;
    case (r_state)
      TX_IDLE_S: if (~w_tx_empty & tx_rdy) w_state_nxt = TX_LOAD_S;
      TX_LOAD_S: begin
        w_tx_pop    = 1'b1;
        w_state_nxt = TX_BUSY_S;
      end
      TX_BUSY_S: if (~tx_rdy | r_busy_cnt) w_state_nxt = TX_IDLE_S;
      default:   w_state_nxt = TX_IDLE_S;
    endcase
  end

  // tx_data is captured on entry to LOAD so it equals the head during LOAD and holds afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= TX_IDLE_S;
      r_busy_cnt <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= (r_state == TX_BUSY_S);
      if (r_state == TX_IDLE_S && w_state_nxt == TX_LOAD_S) r_tx_data <= w_tx_head;
    end
  end

  assign tx_load   = (r_state == TX_LOAD_S) & ~w_lpbk;
  assign tx_data   = r_tx_data;
  assign w_tx_idle = w_tx_empty & (r_state == TX_IDLE_S) & tx_rdy;

  // Sticky flags: a set in the same cycle as a STATUS read wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ferr   <= 1'b0;
      r_perr   <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_ien    <= '0;
    end else begin
      r_ferr   <= (rx_valid & rx_ferr) | (r_ferr & ~w_st_clr);
      r_perr   <= (rx_valid & rx_perr) | (r_perr & ~w_st_clr);
      r_rx_ovf <= (w_rx_push & w_rx_full) | w_lb_drop | (r_rx_ovf & ~w_st_clr);
      r_tx_ovf <= (w_tx_push & w_tx_full) | (r_tx_ovf & ~w_st_clr);
      if (write_strobe & w_sel_ctrl) r_ien <= out_port[3:0];
    end
  end

  assign w_err     = r_ferr | r_perr | r_rx_ovf | r_tx_ovf;
  assign w_irq_src = (r_ien[CT_IE_RX_NEMPTY] & ~w_rx_empty) |
                     (r_ien[CT_IE_TX_NFULL]  & ~w_tx_full)  |
                     (r_ien[CT_IE_ERR]       & w_err)       |
                     (r_ien[CT_IE_TX_EMPTY]  & w_tx_idle);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_src_d <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_irq_src_d <= w_irq_src;
      if (w_irq_src & ~r_irq_src_d) r_irq <= 1'b1;
      else if (interrupt_ack)       r_irq <= 1'b0;
    end
  end

  assign interrupt = r_irq;

  assign w_rx_cnt16 = 16'(w_rx_count);
  assign w_tx_cnt16 = 16'(w_tx_count);
  assign w_rx_cnt8  = (w_rx_cnt16 > 16'd255) ? 8'hFF : w_rx_cnt16[7:0];
  assign w_tx_cnt8  = (w_tx_cnt16 > 16'd255) ? 8'hFF : w_tx_cnt16[7:0];

  assign w_status  = {9'b0, w_tx_idle, r_tx_ovf, r_rx_ovf, r_perr, r_ferr, ~w_tx_full, ~w_rx_empty};
  assign w_ctrl_rb = {11'b0, w_lpbk, r_ien};

  always_comb begin
    in_port = 16'h0000;
    if (w_sel_data && !w_rx_empty) in_port = 16'(w_rx_head);
    else if (w_sel_status)         in_port = w_status;
    else if (w_sel_ctrl)           in_port = w_ctrl_rb;
    else if (w_sel_count)          in_port = {w_rx_cnt8, w_tx_cnt8};
  end

endmodule

// File: tb/tb_uart_port_ctrl.sv
// Directed bench for uart_port_ctrl (default DATA_W=8, DEPTH=16, BASE_ADDR=0);
// the loopback case is selected by UART_LOOPBACK_EN.
module tb_uart_port_ctrl;

  localparam int          DATA_W = 8;
  localparam int          DEPTH  = 16;
  localparam logic [15:0] BASE   = 16'h0000;
  localparam logic [15:0] A_DATA   = BASE + 16'd0;
  localparam logic [15:0] A_STATUS = BASE + 16'd1;
  localparam logic [15:0] A_CTRL   = BASE + 16'd2;
  localparam logic [15:0] A_COUNT  = BASE + 16'd3;

  logic              clk, reset;
  logic [15:0]       port_id, out_port, in_port;
  logic              write_strobe, read_strobe, interrupt, interrupt_ack;
  logic [DATA_W-1:0] tx_data, rx_data;
  logic              tx_load, tx_rdy, rx_valid, rx_ferr, rx_perr;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  uart_port_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .tx_data(tx_data),
    .tx_load(tx_load), .tx_rdy(tx_rdy), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ferr(rx_ferr), .rx_perr(rx_perr)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every character launched toward the TX engine
  always @(negedge clk) begin
    if (tx_load === 1'b1) got_q.push_back(tx_data);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    port_id = addr; out_port = data; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    port_id = addr; read_strobe = 1'b1;
    #1 chk(tag, in_port, exp);
    tick();
    read_strobe = 1'b0;
  endtask

  task automatic peek(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    port_id = addr; read_strobe = 1'b0;
    #1 chk(tag, in_port, exp);
  endtask

  task automatic rx(input logic [7:0] d, input logic f, input logic p);
    rx_data = d; rx_ferr = f; rx_perr = p; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_ferr = 1'b0; rx_perr = 1'b0;
  endtask

  task automatic cmp_loads(input string tag);
    chk({tag, "_n"}, 16'(got_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got_q.size()) ? 16'(got_q[i]) : 16'hFFFF, 16'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; port_id = '0; out_port = '0; write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; tx_rdy = 1'b0; rx_data = '0; rx_valid = 1'b0;
    rx_ferr = 1'b0; rx_perr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_irq", 16'(interrupt), 16'h0);
    chk("rst_tx_load", 16'(tx_load), 16'h0);
    chk("rst_tx_data", 16'(tx_data), 16'h0);
    peek(A_STATUS, 16'h0002, "rst_status");
    peek(A_CTRL, 16'h0000, "rst_ctrl");
    peek(A_COUNT, 16'h0000, "rst_count");

    // Two characters launched in order
    got_q.delete();
    tx_rdy = 1'b1;
    wr(A_DATA, 16'h0041); exp_q.push_back(8'h41);
    wr(A_DATA, 16'h0042); exp_q.push_back(8'h42);
    repeat (12) tick();
    cmp_loads("tx_two");
    peek(A_COUNT, 16'h0000, "tx_two_count");
    peek(A_STATUS, 16'h0042, "tx_two_status");
    chk("tx_hold", 16'(tx_data), 16'h0042);

    // TX overflow with engine stalled
    tx_rdy = 1'b0;
    for (int i = 0; i < 17; i++) wr(A_DATA, 16'(i));
    peek(A_COUNT, 16'h0010, "tx_full_count");
    rd(A_STATUS, 16'h0020, "tx_ovf_status");
    peek(A_STATUS, 16'h0000, "tx_ovf_cleared");

    // Reset in the middle of draining
    got_q.delete();
    tx_rdy = 1'b1;
    repeat (6) tick();
    chk("drain_first", (got_q.size() > 0) ? 16'(got_q[0]) : 16'hFFFF, 16'h0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_rst_tx_load", 16'(tx_load), 16'h0);
    chk("post_rst_tx_data", 16'(tx_data), 16'h0);
    peek(A_COUNT, 16'h0000, "post_rst_count");
    peek(A_STATUS, 16'h0042, "post_rst_status");
    tick();
    chk("post_rst_tx_load2", 16'(tx_load), 16'h0);
    got_q.delete();

    // RX overflow and in-order readout
    for (int i = 0; i < 17; i++) rx(8'(8'h10 + i), 1'b0, 1'b0);
    peek(A_COUNT, 16'h1000, "rx_full_count");
    peek(A_STATUS, 16'h0053, "rx_ovf_status");
    for (int i = 0; i < 16; i++) rd(A_DATA, 16'(8'h10 + i), "rx_order");
    rd(A_DATA, 16'h0000, "rx_empty_read");
    peek(A_COUNT, 16'h0000, "rx_drained_count");
    rd(A_STATUS, 16'h0052, "rx_ovf_read");
    peek(A_STATUS, 16'h0042, "rx_ovf_cleared");

    // Error flag set during STATUS read survives; other flags clear
    rx(8'h01, 1'b0, 1'b1);
    peek(A_STATUS, 16'h004B, "perr_status");
    port_id = A_STATUS; read_strobe = 1'b1;
    rx_data = 8'h02; rx_ferr = 1'b1; rx_valid = 1'b1;
    #1 chk("status_read_race", in_port, 16'h004B);
    tick();
    read_strobe = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0;
    peek(A_STATUS, 16'h0047, "ferr_set_wins");
    rd(A_DATA, 16'h0001, "err_char0");
    rd(A_DATA, 16'h0002, "err_char1");
    rd(A_STATUS, 16'h0046, "ferr_read");
    peek(A_STATUS, 16'h0042, "ferr_cleared");

    // RX_NEMPTY interrupt, acknowledge, readout
    wr(A_CTRL, 16'h0001);
    rd(A_CTRL, 16'h0001, "ctrl_rb");
    rx(8'h55, 1'b0, 1'b0);
    chk("irq_not_yet", 16'(interrupt), 16'h0);
    tick();
    chk("irq_rx", 16'(interrupt), 16'h1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("irq_acked", 16'(interrupt), 16'h0);
    rd(A_DATA, 16'h0055, "irq_data");

    // All enables: TX_NFULL edge raises interrupt; CTRL[4] only kept with loopback
    wr(A_CTRL, 16'h001F);
`ifdef UART_LOOPBACK_EN
    rd(A_CTRL, 16'h001F, "ctrl_all");
`else
    rd(A_CTRL, 16'h000F, "ctrl_all");
`endif
    chk("irq_tx_nfull", 16'(interrupt), 16'h1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("irq_ack_level", 16'(interrupt), 16'h0);
    wr(A_CTRL, 16'h0000);

    // Loopback on CTRL[4]
    got_q.delete();
    wr(A_CTRL, 16'h0010);
`ifdef UART_LOOPBACK_EN
    peek(A_CTRL, 16'h0010, "lpbk_ctrl");
    wr(A_DATA, 16'h00A5);
    repeat (8) tick();
    cmp_loads("lpbk_no_load");
    rd(A_DATA, 16'h00A5, "lpbk_rx");
`else
    peek(A_CTRL, 16'h0000, "lpbk_ctrl");
    wr(A_DATA, 16'h00A5); exp_q.push_back(8'hA5);
    repeat (8) tick();
    cmp_loads("nolpbk_load");
    rd(A_DATA, 16'h0000, "nolpbk_rx");
`endif

    // Unmapped address reads zero
    peek(BASE + 16'd4, 16'h0000, "unmapped");
    peek(16'hFFFF, 16'h0000, "unmapped_hi");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
